// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, stability-count debouncer, and
// derived edge pulses, press-toggle state and long-press hold detection.
module debounce_bank #(
  parameter int unsigned       NUM_CH      = 8,
  parameter int unsigned       COUNT_MAX   = 1000000,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       HOLD_CYCLES = 100000000,
  parameter logic [NUM_CH-1:0] INIT_VAL    = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_noisy,
  output logic [NUM_CH-1:0] o_clean,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_toggle,
  output logic [NUM_CH-1:0] o_held,
  output logic              o_any_change
);

  localparam int unsigned   CW      = $clog2(COUNT_MAX + 1);
  localparam int unsigned   HW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(COUNT_MAX - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
  logic [NUM_CH-1:0][CW-1:0]          r_cnt;
  logic [NUM_CH-1:0][HW-1:0]          r_hold;
  logic [NUM_CH-1:0]                  r_clean;
  logic [NUM_CH-1:0]                  r_rise;
  logic [NUM_CH-1:0]                  r_fall;
  logic [NUM_CH-1:0]                  r_toggle;

  logic [NUM_CH-1:0]                  w_sync;
  logic [NUM_CH-1:0][CW-1:0]          w_cnt_d;
  logic [NUM_CH-1:0][HW-1:0]          w_hold_d;
  logic [NUM_CH-1:0]                  w_clean_d;
  logic [NUM_CH-1:0]                  w_rise_d;
  logic [NUM_CH-1:0]                  w_fall_d;
  logic [NUM_CH-1:0]                  w_held;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Next-state for stability counters, accepted level, edge pulses and hold counters.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_hold_d  = r_hold;
    w_clean_d = r_clean;
    w_rise_d  = '0;
    w_fall_d  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (w_sync[i] == r_clean[i]) begin
        // Any agreeing cycle restarts the count, rejecting short glitches.
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CntLast) begin
        w_clean_d[i] = w_sync[i];
        w_cnt_d[i]   = '0;
        w_rise_d[i]  = w_sync[i];
        w_fall_d[i]  = ~w_sync[i];
      end else begin
        w_cnt_d[i] = r_cnt[i] + CW'(1);
      end

      // Hold counter follows the new clean level so it clears on the falling edge itself.
      if (!w_clean_d[i]) begin
        w_hold_d[i] = '0;
      end else if (r_hold[i] != HoldMax) begin
        w_hold_d[i] = r_hold[i] + HW'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync   <= {SYNC_STAGES{INIT_VAL}};
      r_cnt    <= '0;
      r_hold   <= '0;
      r_clean  <= INIT_VAL;
      r_rise   <= '0;
      r_fall   <= '0;
      r_toggle <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_noisy};
      r_cnt    <= w_cnt_d;
      r_hold   <= w_hold_d;
      r_clean  <= w_clean_d;
      r_rise   <= w_rise_d;
      r_fall   <= w_fall_d;
      r_toggle <= r_toggle ^ w_rise_d;
    end
  end

  // Long-press level decoded from the registered hold counter.
  always_comb begin
    w_held = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_held[i] = (r_hold[i] == HoldMax);
    end
  end

  assign o_clean      = r_clean;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_toggle     = r_toggle;
  assign o_held       = w_held;
  assign o_any_change = |(r_rise | r_fall);

endmodule
